if_stage: RTL and testbench

Instruction fetch stage. It is the producer end of the decode-stage interface and supplies `inst` and `inst_addr` to `id_stage`.
- Holds the PC and issues one-outstanding 32-bit instruction requests to instruction memory.
- Buffers returned instructions in a 2-entry FIFO toward decode.
- Handles redirects from execute (branch/jump target) and stops fetching after the termination instruction (opcode 7'h6b).

---
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, one-outstanding imem request, 2-entry FIFO toward decode.
// Optional IF_PERF_CNT_EN adds fetch/flush event counters.
module if_stage #(
  parameter logic [63:0] PC_RESET   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] addr;
  } fetch_ent_t;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      req_addr_q, req_addr_d;
  fetch_ent_t [1:0] ent_q, ent_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  logic accept, push, pop;

  // Outputs are forced low while reset is held, even though pc already sits at PC_RESET.
  assign imem_req_valid = rst && (state_q == S_IDLE) && (cnt_q < 2'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = rst ? pc_q : 64'h0;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop            = inst_ready && (cnt_q != 2'd0);

  assign inst_valid = (cnt_q != 2'd0);
  assign inst       = inst_valid ? ent_q[rd_ptr_q].inst : 32'h0;
  assign inst_addr  = inst_valid ? ent_q[rd_ptr_q].addr : 64'h0;
  assign halted     = (state_q == S_HALT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ent_d      = ent_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (redirect_valid) begin
      pc_d     = {redirect_target[63:2], 2'b00};
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      // An outstanding response that has not yet returned must be swallowed.
      case (state_q)
        S_WAIT, S_DRAIN: state_d = imem_rsp_valid ? S_IDLE : S_DRAIN;
        default:         state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          pc_d       = pc_q + 64'd4;
          req_addr_d = pc_q;
          state_d    = S_WAIT;
        end
        S_WAIT: if (imem_rsp_valid)
          state_d = (imem_rsp_data[6:0] == 7'h6b) ? S_HALT : S_IDLE;
        S_DRAIN: if (imem_rsp_valid) state_d = S_IDLE;
        default: ;
      endcase
      if (push) begin
        ent_d[wr_ptr_q] = '{inst: imem_rsp_data, addr: req_addr_q};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      req_addr_q <= '0;
      ent_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ent_q      <= ent_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 64'(push);
    flush_cnt_d = flush_cnt_q + 64'(redirect_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a queue-based fetch model plus a random-latency memory.
module tb_if_stage;
  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        halted;

  always #5 clk = ~clk;

  if_stage #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_addr(inst_addr),
    .halted(halted)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] addr;
  } ent_t;

  // Reference model: PC, delivered-entry queue, outstanding / to-be-dropped response flags.
  ent_t        mq[$];
  logic [63:0] m_pc, m_paddr;
  bit          m_pend, m_drop, m_halt;
  bit          mem_busy;
  int          mem_dly;
  int          ready_pct;

  function automatic void model_reset();
    mq.delete();
    m_pc     = PC_RESET;
    m_paddr  = '0;
    m_pend   = 0;
    m_drop   = 0;
    m_halt   = 0;
    mem_busy = 0;
    mem_dly  = 0;
  endfunction

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    else                           t = PC_RESET + 64'($urandom_range(0, 'h1ff));
    return t;
  endfunction

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_req_valid"}, 64'(imem_req_valid), 64'h0);
    check({pfx, "_req_addr"},  imem_req_addr, 64'h0);
    check({pfx, "_inst_valid"}, 64'(inst_valid), 64'h0);
    check({pfx, "_inst"},      64'(inst), 64'h0);
    check({pfx, "_inst_addr"}, inst_addr, 64'h0);
    check({pfx, "_halted"},    64'(halted), 64'h0);
  endtask

  task automatic cycle();
    bit          exp_rv;
    logic [31:0] r;
    ent_t        e;
    @(negedge clk);
    imem_req_ready  = ($urandom_range(0, 3) != 0);
    inst_ready      = ($urandom_range(0, 99) < ready_pct);
    redirect_valid  = ($urandom_range(0, 19) == 0);
    redirect_target = pick_target();
    imem_rsp_valid  = mem_busy && (mem_dly == 0);
    r               = $urandom;
    imem_rsp_data   = ($urandom_range(0, 15) == 0) ? {r[31:7], 7'h6b} : r;
    #1;
    exp_rv = !m_halt && !m_pend && !m_drop && (mq.size() < 2) && !redirect_valid;
    check("req_valid",  64'(imem_req_valid), 64'(exp_rv));
    check("req_addr",   imem_req_addr, m_pc);
    check("inst_valid", 64'(inst_valid), 64'(mq.size() != 0));
    check("inst",       64'(inst), (mq.size() != 0) ? 64'(mq[0].inst) : 64'h0);
    check("inst_addr",  inst_addr, (mq.size() != 0) ? mq[0].addr : 64'h0);
    check("halted",     64'(halted), 64'(m_halt));
    // memory responds to what the DUT actually issued
    if (imem_rsp_valid) mem_busy = 0;
    else if (mem_busy) mem_dly--;
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1;
      mem_dly  = $urandom_range(0, 2);
    end
    if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_target & ~64'h3;
      m_halt = 0;
      if (m_pend) begin
        m_pend = 0;
        m_drop = !imem_rsp_valid;
      end else if (m_drop && imem_rsp_valid) m_drop = 0;
    end else begin
      if (inst_ready && mq.size() != 0) e = mq.pop_front();
      if (m_pend && imem_rsp_valid) begin
        e.inst = imem_rsp_data;
        e.addr = m_paddr;
        mq.push_back(e);
        m_pend = 0;
        if (imem_rsp_data[6:0] == 7'h6b) m_halt = 1;
      end else if (m_drop && imem_rsp_valid) m_drop = 0;
      if (exp_rv && imem_req_ready) begin
        m_pend  = 1;
        m_paddr = m_pc;
        m_pc    = m_pc + 64'd4;
      end
    end
  endtask

  initial begin
    bit found;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_target = '0; inst_ready = 0;
    ready_pct = 100;
    model_reset();
    @(negedge clk); #1;
    check_idle_outputs("rst");
    @(negedge clk);
    rst = 1'b1;

    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0:       ready_pct = 100;
        1:       ready_pct = 50;
        default: ready_pct = 5;
      endcase
      for (int c = 0; c < 250; c++) cycle();
    end

    // reset while a request is outstanding; the late response must be ignored
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      cycle();
      found = m_pend && !redirect_valid;
    end
    check("find_pending", 64'(found), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 0; redirect_valid = 0; inst_ready = 0; imem_req_ready = 0;
    #1;
    check_idle_outputs("midrst");
    model_reset();
    @(negedge clk);
    imem_rsp_valid = 1;
    #1;
    check_idle_outputs("midrst_rsp");
    @(negedge clk);
    imem_rsp_valid = 0;
    rst = 1'b1;
    ready_pct = 80;
    for (int c = 0; c < 300; c++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
